// File: rtl/delta_frame_locator.sv
// delta_frame_locator: thresholds a raster of delta pixels (clk, reset, enable, delta_valid, frame_start, delta_frame, threshold) and reports per frame result_valid, found, x_min/x_max/y_min/y_max and pixel_count
module delta_frame_locator #(
  parameter int INPUT_WIDTH  = 10,
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int COORD_WIDTH  = 10,
  parameter int COUNT_WIDTH  = 20
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   delta_valid,
  input  logic                   frame_start,
  input  logic [INPUT_WIDTH-1:0] delta_frame,
  input  logic [INPUT_WIDTH-1:0] threshold,
  output logic                   result_valid,
  output logic                   found,
  output logic [COORD_WIDTH-1:0] x_min,
  output logic [COORD_WIDTH-1:0] x_max,
  output logic [COORD_WIDTH-1:0] y_min,
  output logic [COORD_WIDTH-1:0] y_max,
  output logic [COUNT_WIDTH-1:0] pixel_count
);
  typedef enum logic [1:0] {IDLE, ACCUM, REPORT} state_t;
  localparam logic [COORD_WIDTH-1:0] X_LAST = COORD_WIDTH'(FRAME_WIDTH - 1);
  localparam logic [COORD_WIDTH-1:0] Y_LAST = COORD_WIDTH'(FRAME_HEIGHT - 1);
  state_t state, state_n;
  logic take, motion, last, b_found, a_found, n_found;
  logic [COORD_WIDTH-1:0] x, y, px, py, x_n, y_n;
  logic [COORD_WIDTH-1:0] a_x_min, a_x_max, a_y_min, a_y_max;
  logic [COORD_WIDTH-1:0] b_x_min, b_x_max, b_y_min, b_y_max;
  logic [COORD_WIDTH-1:0] n_x_min, n_x_max, n_y_min, n_y_max;
  logic [COUNT_WIDTH-1:0] a_cnt, b_cnt, n_cnt;
  always_comb begin
    take = enable && delta_valid && (state == ACCUM || (state == IDLE && frame_start));
    px = frame_start ? '0 : x;
    py = frame_start ? '0 : y;
    last = px == X_LAST && py == Y_LAST;
    x_n = px == X_LAST ? '0 : px + COORD_WIDTH'(1);
    y_n = px == X_LAST ? (last ? '0 : py + COORD_WIDTH'(1)) : py;
    motion = delta_frame > threshold;
    b_found = !frame_start && a_found;
    b_x_min = frame_start ? '0 : a_x_min;
    b_x_max = frame_start ? '0 : a_x_max;
    b_y_min = frame_start ? '0 : a_y_min;
    b_y_max = frame_start ? '0 : a_y_max;
    b_cnt = frame_start ? '0 : a_cnt;
    n_found = b_found || motion;
    n_x_min = motion && (!b_found || px < b_x_min) ? px : b_x_min;
    n_x_max = motion && (!b_found || px > b_x_max) ? px : b_x_max;
    n_y_min = motion && (!b_found || py < b_y_min) ? py : b_y_min;
    n_y_max = motion && (!b_found || py > b_y_max) ? py : b_y_max;
    n_cnt = motion && !(&b_cnt) ? b_cnt + COUNT_WIDTH'(1) : b_cnt;
    state_n = state == REPORT ? IDLE : take ? (last ? REPORT : ACCUM) : state;
    result_valid = state == REPORT;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      {x, y} <= '0;
      {a_found, a_x_min, a_x_max, a_y_min, a_y_max, a_cnt} <= '0;
      {found, x_min, x_max, y_min, y_max, pixel_count} <= '0;
    end else begin
      state <= state_n;
      if (take) begin
        x <= x_n;
        y <= y_n;
        {a_found, a_x_min, a_x_max, a_y_min, a_y_max, a_cnt} <= {n_found, n_x_min, n_x_max, n_y_min, n_y_max, n_cnt};
      end
      if (take && last)
        {found, x_min, x_max, y_min, y_max, pixel_count} <= {n_found, n_x_min, n_x_max, n_y_min, n_y_max, n_cnt};
    end
  end
endmodule

// File: tb/tb_delta_frame_locator.sv
// tb_delta_frame_locator: table, directed and random checks of delta_frame_locator against a frame-level model
module tb_delta_frame_locator;
  localparam int W = 8, H = 4, N = W * H, CNTW = 5, CMAX = (1 << CNTW) - 1;
  logic clk = 1'b0, reset, enable, delta_valid, frame_start, result_valid, found;
  logic [9:0] delta_frame, threshold, x_min, x_max, y_min, y_max;
  logic [CNTW-1:0] pixel_count;
  int tests = 0, fails = 0;
  bit in_frame = 0, reporting = 0;
  bit mot[N];
  int k = 0;
  int e_rv = 0, e_found = 0, e_xmin = 0, e_xmax = 0, e_ymin = 0, e_ymax = 0, e_cnt = 0;

  typedef struct {int p0, v0, p1, v1, bg, f, xmn, xmx, ymn, ymx, cnt;} vec_t;
  vec_t tbl[6];

  delta_frame_locator #(.INPUT_WIDTH(10), .FRAME_WIDTH(W), .FRAME_HEIGHT(H), .COORD_WIDTH(10), .COUNT_WIDTH(CNTW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .delta_valid(delta_valid), .frame_start(frame_start),
    .delta_frame(delta_frame), .threshold(threshold), .result_valid(result_valid), .found(found),
    .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max), .pixel_count(pixel_count)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic report();
    int c = 0;
    e_found = 0; e_xmin = 0; e_xmax = 0; e_ymin = 0; e_ymax = 0;
    for (int i = 0; i < N; i++) if (mot[i]) begin
      if (c == 0) begin
        e_xmin = i % W; e_xmax = i % W; e_ymin = i / W; e_ymax = i / W;
      end else begin
        if (i % W < e_xmin) e_xmin = i % W;
        if (i % W > e_xmax) e_xmax = i % W;
        if (i / W < e_ymin) e_ymin = i / W;
        if (i / W > e_ymax) e_ymax = i / W;
      end
      c++;
    end
    e_found = c > 0;
    e_cnt = c > CMAX ? CMAX : c;
  endtask

  task automatic step(bit rst, bit en, bit dv, bit fs, int d, int th);
    reset = rst; enable = en; delta_valid = dv; frame_start = fs;
    delta_frame = 10'(d); threshold = 10'(th);
    e_rv = 0;
    if (rst) begin
      in_frame = 0; reporting = 0;
      e_found = 0; e_xmin = 0; e_xmax = 0; e_ymin = 0; e_ymax = 0; e_cnt = 0;
    end else if (reporting) reporting = 0;
    else if (en && dv) begin
      if (fs) begin in_frame = 1; k = 0; end
      if (in_frame) begin
        mot[k] = d > th;
        k++;
        if (k == N) begin
          report();
          e_rv = 1; in_frame = 0; reporting = 1;
        end
      end
    end
    @(posedge clk); #1;
    check("result_valid", 32'(result_valid), e_rv);
    check("found", 32'(found), e_found);
    check("x_min", 32'(x_min), e_xmin);
    check("x_max", 32'(x_max), e_xmax);
    check("y_min", 32'(y_min), e_ymin);
    check("y_max", 32'(y_max), e_ymax);
    check("pixel_count", 32'(pixel_count), e_cnt);
  endtask

  task automatic frame(int p0, int v0, int p1, int v1, int bg, bit gap);
    for (int i = 0; i < N; i++) begin
      step(0, 1, 1, i == 0, i == p0 ? v0 : i == p1 ? v1 : bg, 20);
      if (gap && i % 5 == 4 && i < N - 1)
        for (int j = 0; j < 3; j++) step(0, j != 1, j == 1, 1'($urandom % 2), 99, 20);
    end
  endtask

  task automatic expect_box(string tag, int f, int xmn, int xmx, int ymn, int ymx, int cnt);
    check({tag, "_found"}, 32'(found), f);
    check({tag, "_x_min"}, 32'(x_min), xmn);
    check({tag, "_x_max"}, 32'(x_max), xmx);
    check({tag, "_y_min"}, 32'(y_min), ymn);
    check({tag, "_y_max"}, 32'(y_max), ymx);
    check({tag, "_count"}, 32'(pixel_count), cnt);
  endtask

  initial begin
    tbl[0] = '{10, 50, 29, 50, 0, 1, 2, 5, 1, 3, 2};
    tbl[1] = '{0, 20, 0, 20, 20, 0, 0, 0, 0, 0, 0};
    tbl[2] = '{31, 21, 31, 21, 20, 1, 7, 7, 3, 3, 1};
    tbl[3] = '{0, 1023, 31, 21, 0, 1, 0, 7, 0, 3, 2};
    tbl[4] = '{0, 21, 0, 21, 21, 1, 0, 7, 0, 3, 31};
    tbl[5] = '{12, 25, 19, 30, 0, 1, 3, 4, 1, 2, 2};
    step(1, 0, 0, 0, 0, 20);
    step(1, 1, 1, 1, 99, 20);
    expect_box("reset", 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      frame(tbl[i].p0, tbl[i].v0, tbl[i].p1, tbl[i].v1, tbl[i].bg, 0);
      check("tbl_pulse", 32'(result_valid), 1);
      expect_box("tbl", tbl[i].f, tbl[i].xmn, tbl[i].xmx, tbl[i].ymn, tbl[i].ymx, tbl[i].cnt);
      step(0, 0, 0, 0, 0, 20);
    end
    for (int i = 0; i < 10; i++) step(0, 1, 1, i == 0, i == 3 ? 50 : 0, 20);
    frame(0, 50, -1, 0, 0, 0);
    expect_box("restart", 1, 0, 0, 0, 0, 1);
    step(0, 1, 1, 1, 99, 20);
    for (int i = 0; i < N; i++) step(0, 1, 1, 0, 99, 20);
    expect_box("report_ignore", 1, 0, 0, 0, 0, 1);
    frame(10, 50, 29, 50, 0, 1);
    check("gap_pulse", 32'(result_valid), 1);
    expect_box("gap", 1, 2, 5, 1, 3, 2);
    step(0, 0, 0, 0, 0, 20);
    for (int i = 0; i < 20; i++) step(0, 1, 1, i == 0, i == 5 ? 60 : 0, 20);
    step(1, 1, 1, 1, 99, 20);
    expect_box("mid_reset", 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) step(0, 1, 1, 0, 0, 20);
    frame(12, 25, 19, 30, 0, 0);
    expect_box("after_reset", 1, 3, 4, 1, 2, 2);
    step(0, 0, 0, 0, 0, 20);
    for (int i = 0; i < 10; i++) step(0, 1, 1, 0, 99, 20);
    frame(31, 21, 31, 21, 20, 0);
    expect_box("idle_lead", 1, 7, 7, 3, 3, 1);
    step(0, 0, 0, 0, 0, 20);
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < N; i++) begin
        step(0, 1, 1, i == 0, int'($urandom % 40), int'($urandom_range(18, 22)));
        if ($urandom % 4 == 0 && i < N - 1) step(0, 1'($urandom % 2), 0, 1'($urandom % 2), 99, 20);
      end
      step(0, 0, 0, 0, 0, 20);
    end
    for (int i = 0; i < 600; i++)
      step($urandom % 300 == 0, $urandom % 8 != 0, $urandom % 8 != 0, $urandom % 64 == 0,
           int'($urandom_range(0, 40)), int'($urandom_range(15, 25)));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/delta_frame_locator.md
DELTA_FRAME_LOCATOR -- requirements
Module: delta_frame_locator

Interface
REQ-001 SHALL have parameter INPUT_WIDTH, default 10: delta pixel width.
REQ-002 SHALL have parameter FRAME_WIDTH, default 640: pixels per line.
REQ-003 SHALL have parameter FRAME_HEIGHT, default 480: lines per frame.
REQ-004 SHALL have parameter COORD_WIDTH, default 10: coordinate width; must hold FRAME_WIDTH-1 and FRAME_HEIGHT-1.
REQ-005 SHALL have parameter COUNT_WIDTH, default 20: motion pixel counter width.
REQ-006 SHALL have port clk, input, 1: single clock; all logic on the rising edge.
REQ-007 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port enable, input, 1: when low, input pixels are ignored and state holds.
REQ-009 SHALL have port delta_valid, input, 1: delta_frame carries a pixel this cycle.
REQ-010 SHALL have port frame_start, input, 1: qualified by delta_valid; marks pixel (0,0).
REQ-011 SHALL have port delta_frame, input, INPUT_WIDTH: absolute-difference pixel.
REQ-012 SHALL have port threshold, input, INPUT_WIDTH: motion threshold; sampled every accepted pixel.
REQ-013 SHALL have port result_valid, output, 1: one-cycle pulse; results updated.
REQ-014 SHALL have port found, output, 1: at least one motion pixel in the last frame.
REQ-015 SHALL have ports x_min, x_max, y_min, y_max, output, COORD_WIDTH each: motion bounding box, inclusive.
REQ-016 SHALL have port pixel_count, output, COUNT_WIDTH: number of motion pixels in the last frame.

Function
REQ-017 An accepted pixel SHALL be a cycle with enable=1 and delta_valid=1; all other cycles SHALL leave counters, accumulators and state unchanged.
REQ-018 A motion pixel SHALL be an accepted pixel with delta_frame > threshold (strict, unsigned); equality SHALL NOT be motion.
REQ-019 SHALL implement FSM states IDLE, ACCUM, REPORT; the reset state SHALL be IDLE.
REQ-020 IDLE: accepted pixels without frame_start SHALL be discarded; an accepted pixel with frame_start SHALL be processed as (0,0), clear all accumulators first, and move the FSM to ACCUM.
REQ-021 ACCUM: each accepted pixel SHALL advance x; at x=FRAME_WIDTH-1, x SHALL wrap to 0 and y SHALL increment.
REQ-022 ACCUM: an accepted pixel with frame_start SHALL abandon the partial frame and restart at (0,0) with cleared accumulators; no result SHALL be reported for the abandoned frame.
REQ-023 For each motion pixel at (x,y), the internal box SHALL update to min/max of the held values and (x,y); the first motion pixel of a frame SHALL load all four bounds directly.
REQ-024 The internal motion counter SHALL increment per motion pixel and saturate at all-ones.
REQ-025 Acceptance of pixel (FRAME_WIDTH-1, FRAME_HEIGHT-1) SHALL move the FSM to REPORT; that pixel's contribution SHALL be included.
REQ-026 REPORT SHALL last exactly one cycle: outputs load from the accumulators, result_valid=1, next state IDLE; input pixels during REPORT SHALL be ignored.
REQ-027 result_valid SHALL rise exactly one cycle after the last pixel is accepted.
REQ-028 If no motion pixel occurred, REPORT SHALL output found=0, all bounds 0, and pixel_count=0.
REQ-029 found, bounds and pixel_count SHALL hold their values between REPORT cycles.
REQ-030 Arithmetic SHALL be unsigned; comparisons SHALL be at full input/coordinate width with no truncation.

Reset
REQ-031 reset=1 SHALL, on the next rising edge, set the FSM to IDLE, x=y=0, clear all accumulators, and set result_valid=0, found=0, x_min=x_max=y_min=y_max=0, and pixel_count=0.
REQ-032 reset SHALL override enable, delta_valid and frame_start; reset mid-frame SHALL discard that frame with no result pulse.

Verification (FRAME_WIDTH=8, FRAME_HEIGHT=4, threshold=20)
REQ-033 Frame of 32 zeros, with delta=50 at (2,1) and (5,3) -> one result_valid pulse one cycle after the 32nd pixel; found=1, box x 2..5, y 1..3, count=2.
REQ-034 Frame with all pixels=20 -> found=0, bounds 0, count=0; pixel=21 at (7,3) only -> box (7,7,3,3), count=1.
REQ-035 frame_start at pixel 10 of a frame, then a full 32-pixel frame with motion at (0,0) -> single pulse; box (0,0,0,0), count=1.
REQ-036 enable=0 or delta_valid=0 gaps of 3 cycles inserted every 5 pixels -> results identical to the gap-free run; pulse one cycle after the final accepted pixel.
REQ-037 reset asserted at pixel 20, then a clean frame -> no pulse for the aborted frame; all outputs 0 after reset; the next frame reports correctly.
REQ-038 Pixels without frame_start in IDLE, then a valid frame -> the leading pixels are ignored and the results reflect only the valid frame.
